proj_lanex: RTL and testbench
=============================

# proj_lanex

Single-clock, multi-channel traffic generator and checker for exercising a valid/ready datapath under test, such as a FIFO or pipeline, in loopback. The generator interleaves C independent per-channel sequences, either counter or LFSR, tags each word with its channel, and drives them out through a valid/ready source port. The checker accepts tagged words back and compares each against a per-channel expected sequence. It keeps saturating per-channel error counters, sticky error flags, a bad-tag flag, and a completion indication.

## Interface
- W, 16: data width.
- C, 2: channel count, 1..2^CW.
- CW, 1: tag width.
- EW, 8: error counter width per channel.
- X, 1: counter-mode step added per word.
- MODE, 0: 0 = counter sequence, 1 = Galois LFSR sequence.
- POLY, 16'hB400: LFSR feedback taps, W bits.
- N, 0: words per channel before stopping; 0 = run forever.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  generator enable.
- wrdata  out  W  generated word.
- wrtag  out  CW  channel of wrdata.
- wrvld  out  1  wrdata/wrtag valid.
- wrrdy  in  1  sink accepts.
- rddata  in  W  returned word.
- rdtag  in  CW  channel of rddata.
- rdvld  in  1  returned word valid.
- rdrdy  out  1  checker ready.
- errcntrs  out  C*EW  per-channel error counts; channel c at bits [c*EW +: EW].
- errflgs  out  C  sticky per-channel error flags.
- tagerr  out  1  sticky: a word arrived with rdtag >= C.
- done  out  1  all channels generated and checked N words.

## Operation
- Sequences, per channel c:
  - Counter mode: first value 0; next = value + X, modulo 2^W, wrapping silently.
  - LFSR mode: seed c+1; next = (s>>1) ^ (s[0] ? POLY : 0).
- Generator:
  - Current channel pointer starts at 0.
  - The word presented is gen[ptr], tagged ptr.
  - On accept (wrvld && wrrdy): gen[ptr] advances, ptr = (ptr+1) mod C, and the per-channel sent count increments.
  - A channel whose sent count equals N (N>0) is skipped. The pointer moves to the next channel with count < N.
- Generator valid rules:
  - wrvld rises only when en=1 and some channel is below N.
  - Once asserted, wrvld, wrdata and wrtag hold stable until accepted, regardless of en.
  - After the accept, wrvld stays low while en=0.
- Checker:
  - rdrdy = 1 whenever rst = 1.
  - Each beat (rdvld && rdrdy) with rdtag < C compares rddata to exp[rdtag].
  - exp[rdtag] then advances from its own expected value, not from rddata. A single corrupt word therefore causes exactly one error.
  - Per-channel receive count increments on every beat.
- Error counting:
  - Mismatch: errcntrs[rdtag] increments, saturating at 2^EW-1 (no wrap).
  - errflgs[rdtag] sets and stays set until reset.
  - rdtag >= C: tagerr sets; no counter or exp changes.
- done: N>0 and every channel's receive count equals N. Held until reset. Always 0 when N=0.
- Beats received after done are still checked.

## Timing
- Reset (rst=0 at an edge), all registered:
  - wrvld=0, wrdata=0, wrtag=0, rdrdy=0.
  - errcntrs=0, errflgs=0, tagerr=0, done=0.
  - Sequences, pointer and counts return to initial values.
- Reset mid-operation discards any pending word without accept.
- All outputs are registered; there is no combinational path from inputs to outputs.
- With en=1 held across reset release at edge k, wrvld=1 from edge k+1.
- Throughput is one word per cycle with wrrdy held high.
- A beat at edge k:
  - errcntrs/errflgs/tagerr reflect it after edge k+1.
  - done asserts after edge k+1 following the final Nth beat.
- Simultaneous generate and check on the same channel are independent; both occur in the same cycle.
- A beat at saturation leaves errcntrs unchanged while errflgs remains 1.

## Test plan
- **Loopback:** C=2, MODE=0, X=1, N=4, wrrdy=1, wr* wired to rd*, en=1 -> words (tag,data) = (0,0),(1,0),(0,1),(1,1),… through (1,3). wrvld falls after 8 accepts; done=1; errcntrs=0.
- **Backpressure:** random wrrdy at 50% -> wrdata/wrtag never change while wrvld && !wrrdy. Checker sees the same 8 words with no errors. Dropping en mid-stall still completes the pending word.
- **Single corruption:** flip bit 0 of the 3rd channel-1 word -> errcntrs ch1=1, errflgs=2'b10, ch0=0. Later channel-1 words produce no further errors.
- **Saturation:** EW=2, invert all channel-0 returns for 10 words -> ch0 count stops at 3; errflgs[0]=1.
- **LFSR:** MODE=1, C=1 -> wrdata sequence 0x0001, 0xB400, 0x5A00, 0x2D00; loopback error-free.
- **Bad tag and reset:** inject a beat with rdtag=3 (C=2, CW=2) -> tagerr=1 with counters unchanged. Then assert rst=0 for one cycle mid-stream -> all outputs 0, and the sequences restart at their initial values.

Source files
------------

// File: rtl/proj_lanex.sv
// Multi-channel valid/ready traffic generator and loopback checker.
// Interleaves per-channel counter or LFSR sequences and checks tagged returns against them.
module proj_lanex #(
  parameter int             W    = 16,
  parameter int             C    = 2,
  parameter int             CW   = 1,
  parameter int             EW   = 8,
  parameter int             X    = 1,
  parameter int             MODE = 0,
  parameter logic [W-1:0]   POLY = 16'hB400,
  parameter int             N    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [W-1:0]      wrdata,
  output logic [CW-1:0]     wrtag,
  output logic              wrvld,
  input  logic              wrrdy,
  input  logic [W-1:0]      rddata,
  input  logic [CW-1:0]     rdtag,
  input  logic              rdvld,
  output logic              rdrdy,
  output logic [C*EW-1:0]   errcntrs,
  output logic [C-1:0]      errflgs,
  output logic              tagerr,
  output logic              done
);

  localparam logic [31:0] NMAX       = 32'(N);
  localparam logic        RUNFOREVER = (N == 0);
  localparam logic [CW:0] CNUM       = (CW+1)'(C);

  function automatic logic [W-1:0] seq_step(input logic [W-1:0] s);
    logic [W-1:0] r;
    if (MODE == 1) r = (s >> 1) ^ (s[0] ? POLY : {W{1'b0}});
    else           r = s + W'(X);
    return r;
  endfunction

  function automatic logic [W-1:0] seq_seed(input int c);
    return (MODE == 1) ? W'(c + 1) : {W{1'b0}};
  endfunction

  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
    return (c == CW'(C - 1)) ? {CW{1'b0}} : c + CW'(1'b1);
  endfunction

  logic [W-1:0]    gen_r      [C];
  logic [W-1:0]    gen_nxt_s  [C];
  logic [31:0]     sent_r     [C];
  logic [31:0]     sent_nxt_s [C];
  logic [CW-1:0]   ptr_r, ptr_nxt_s, cand_s;
  logic            acc_s, left_s, found_s, hit_s;
  logic            wrvld_r;
  logic [W-1:0]    wrdata_r;
  logic [CW-1:0]   wrtag_r;

  logic            rdrdy_r, beat_r;
  logic [W-1:0]    bdata_r;
  logic [CW-1:0]   btag_r;
  logic [W-1:0]    exp_r      [C];
  logic [31:0]     rcv_r      [C];
  logic [31:0]     rcv_nxt_s  [C];
  logic [C-1:0]    chk_s;
  logic            tagok_s, mism_s, alldone_s;
  logic [C*EW-1:0] errcnt_r;
  logic [C-1:0]    errflg_r;
  logic            tagerr_r, done_r;

  // Sequence, count and round-robin pointer updates caused by an accept
  always_comb begin
    acc_s  = wrvld_r & wrrdy;
    left_s = RUNFOREVER;
    for (int c = 0; c < C; c++) begin
      gen_nxt_s[c]  = (acc_s && wrtag_r == CW'(c)) ? seq_step(gen_r[c]) : gen_r[c];
      sent_nxt_s[c] = (acc_s && wrtag_r == CW'(c)) ? sent_r[c] + 32'd1 : sent_r[c];
      left_s        = left_s | (sent_nxt_s[c] < NMAX);
    end
    ptr_nxt_s = ptr_r;
    cand_s    = wrtag_r;
    found_s   = 1'b0;
    hit_s     = 1'b0;
    // walk forward from the accepted channel, skipping channels that reached N
    for (int i = 0; i < C; i++) begin
      cand_s    = next_ch(cand_s);
      hit_s     = !found_s && (RUNFOREVER || sent_nxt_s[cand_s] < NMAX);
      ptr_nxt_s = (acc_s && hit_s) ? cand_s : ptr_nxt_s;
      found_s   = found_s | hit_s;
    end
  end

  // Generator state and the registered source port
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < C; c++) begin
        gen_r[c]  <= seq_seed(c);
        sent_r[c] <= 32'd0;
      end
      ptr_r    <= {CW{1'b0}};
      wrvld_r  <= 1'b0;
      wrdata_r <= {W{1'b0}};
      wrtag_r  <= {CW{1'b0}};
    end else begin
      for (int c = 0; c < C; c++) begin
        gen_r[c]  <= gen_nxt_s[c];
        sent_r[c] <= sent_nxt_s[c];
      end
      ptr_r <= ptr_nxt_s;
      if (wrvld_r && !wrrdy) begin
        wrvld_r <= 1'b1;
      end else if (en && left_s) begin
        wrvld_r  <= 1'b1;
        wrdata_r <= gen_nxt_s[ptr_nxt_s];
        wrtag_r  <= ptr_nxt_s;
      end else begin
        wrvld_r <= 1'b0;
      end
    end
  end

  // Returned beats are staged one cycle so results appear the edge after the beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdrdy_r <= 1'b0;
      beat_r  <= 1'b0;
      bdata_r <= {W{1'b0}};
      btag_r  <= {CW{1'b0}};
    end else begin
      rdrdy_r <= 1'b1;
      beat_r  <= rdvld & rdrdy_r;
      bdata_r <= rddata;
      btag_r  <= rdtag;
    end
  end

  // Compare the staged beat and derive receive counts and completion
  always_comb begin
    tagok_s   = ({1'b0, btag_r} < CNUM);
    mism_s    = 1'b0;
    alldone_s = !RUNFOREVER;
    for (int c = 0; c < C; c++) begin
      chk_s[c]     = beat_r && tagok_s && (btag_r == CW'(c));
      mism_s       = mism_s | (chk_s[c] && (bdata_r != exp_r[c]));
      rcv_nxt_s[c] = chk_s[c] ? rcv_r[c] + 32'd1 : rcv_r[c];
      alldone_s    = alldone_s & (rcv_nxt_s[c] == NMAX);
    end
  end

  // Checker state: expected sequences advance on their own, never from rddata
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < C; c++) begin
        exp_r[c] <= seq_seed(c);
        rcv_r[c] <= 32'd0;
      end
      errcnt_r <= {(C*EW){1'b0}};
      errflg_r <= {C{1'b0}};
      tagerr_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      for (int c = 0; c < C; c++) begin
        rcv_r[c] <= rcv_nxt_s[c];
        if (chk_s[c]) begin
          exp_r[c] <= seq_step(exp_r[c]);
        end
        if (chk_s[c] && mism_s) begin
          errflg_r[c] <= 1'b1;
          if (errcnt_r[c*EW +: EW] != {EW{1'b1}}) begin
            errcnt_r[c*EW +: EW] <= errcnt_r[c*EW +: EW] + EW'(1'b1);
          end
        end
      end
      if (beat_r && !tagok_s) begin
        tagerr_r <= 1'b1;
      end
      done_r <= done_r | alldone_s;
    end
  end

  assign wrvld    = wrvld_r;
  assign wrdata   = wrdata_r;
  assign wrtag    = wrtag_r;
  assign rdrdy    = rdrdy_r;
  assign errcntrs = errcnt_r;
  assign errflgs  = errflg_r;
  assign tagerr   = tagerr_r;
  assign done     = done_r;

endmodule

// File: tb/tb_proj_lanex.sv
// Randomized loopback bench for proj_lanex: a counter-mode instance checked every cycle
// against a word-list/receive-count model, plus an LFSR instance pinned by literal values.
module tb_proj_lanex;
  localparam int W = 16, C = 2, CW = 2, EW = 2, N = 10, X = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, wrrdy, rdvld, wrvld, rdrdy, tagerr, done;
  logic [W-1:0] wrdata, rddata;
  logic [CW-1:0] wrtag, rdtag;
  logic [C*EW-1:0] errcntrs;
  logic [C-1:0] errflgs;

  logic l_en, l_wrvld, l_wrrdy, l_rdvld, l_rdrdy, l_tagerr, l_done;
  logic [15:0] l_wrdata, l_rddata;
  logic [0:0] l_wrtag, l_rdtag, l_errflgs;
  logic [7:0] l_errcntrs;

  proj_lanex #(.W(W), .C(C), .CW(CW), .EW(EW), .X(X), .MODE(0), .POLY(16'hB400), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .wrdata(wrdata), .wrtag(wrtag), .wrvld(wrvld), .wrrdy(wrrdy),
    .rddata(rddata), .rdtag(rdtag), .rdvld(rdvld), .rdrdy(rdrdy), .errcntrs(errcntrs),
    .errflgs(errflgs), .tagerr(tagerr), .done(done));

  proj_lanex #(.W(16), .C(1), .CW(1), .EW(8), .X(1), .MODE(1), .POLY(16'hB400), .N(4)) dut_lfsr (
    .clk(clk), .rst(rst), .en(l_en), .wrdata(l_wrdata), .wrtag(l_wrtag), .wrvld(l_wrvld),
    .wrrdy(l_wrrdy), .rddata(l_rddata), .rdtag(l_rdtag), .rdvld(l_rdvld), .rdrdy(l_rdrdy),
    .errcntrs(l_errcntrs), .errflgs(l_errflgs), .tagerr(l_tagerr), .done(l_done));

  int total = 0;
  int bad = 0;
  logic armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the full generation order as a list, and per-channel receive counts.
  logic [CW-1:0] ord_tag [2*N];
  logic [W-1:0]  ord_dat [2*N];
  int m_idx;
  logic m_vld, m_rdrdy, m_tagerr, v_tagerr, v_done, alld;
  logic [CW-1:0] m_tag;
  logic [W-1:0] m_dat;
  int m_rcv [C];
  int m_err [C];
  int v_err [C];
  logic [C-1:0] m_flg, v_flg;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_idx = 0; m_vld = 1'b0; m_tag = '0; m_dat = '0; m_rdrdy = 1'b0;
      m_tagerr = 1'b0; v_tagerr = 1'b0; v_done = 1'b0; m_flg = '0; v_flg = '0;
      for (int c = 0; c < C; c++) begin m_rcv[c] = 0; m_err[c] = 0; v_err[c] = 0; end
    end else begin
      v_err = m_err; v_flg = m_flg; v_tagerr = m_tagerr;
      alld = 1'b1;
      for (int c = 0; c < C; c++) if (m_rcv[c] != N) alld = 1'b0;
      v_done = v_done | alld;
      if (rdvld && m_rdrdy) begin
        if (int'(rdtag) >= C) m_tagerr = 1'b1;
        else begin
          if (rddata != W'(m_rcv[rdtag] * X)) begin
            m_flg[rdtag] = 1'b1;
            if (m_err[rdtag] < 3) m_err[rdtag]++;
          end
          m_rcv[rdtag]++;
        end
      end
      m_rdrdy = 1'b1;
      if (m_vld && wrrdy) m_idx++;
      if (!(m_vld && !wrrdy)) begin
        m_vld = en && (m_idx < 2*N);
        if (m_vld) begin m_tag = ord_tag[m_idx]; m_dat = ord_dat[m_idx]; end
      end
    end
  end

  logic [C*EW-1:0] e_cnt;
  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int c = 0; c < C; c++) e_cnt[c*EW +: EW] = EW'(v_err[c]);
      chk("wrvld", wrvld, m_vld);
      if (m_vld) begin
        chk("wrtag", wrtag, m_tag);
        chk("wrdata", wrdata, m_dat);
      end
      chk("rdrdy", rdrdy, m_rdrdy);
      chk("errcntrs", errcntrs, e_cnt);
      chk("errflgs", errflgs, v_flg);
      chk("tagerr", tagerr, v_tagerr);
      chk("done", done, v_done);
    end
  end

  int nacc, c1, ln;
  logic [CW-1:0] f_tag [4];
  logic [W-1:0] f_dat [4];
  logic [15:0] lw [4];

  task automatic drive(input logic e, input int mode, input int pct);
    @(negedge clk);
    en = e;
    wrrdy = ($urandom_range(0, 99) < pct);
    rdvld = wrvld && wrrdy;
    rdtag = wrtag;
    rddata = wrdata;
    if (rdvld && mode == 1 && wrtag == 2'd1) begin
      c1++;
      if (c1 == 3) rddata = wrdata ^ 16'h0001;
    end
    if (rdvld && mode == 2 && wrtag == 2'd0) rddata = ~wrdata;
    if (rdvld && nacc < 4) begin f_tag[nacc] = wrtag; f_dat[nacc] = wrdata; end
    if (rdvld) nacc++;
    l_rdvld = l_wrvld; l_rddata = l_wrdata; l_rdtag = l_wrtag;
    if (l_wrvld && ln < 4) lw[ln] = l_wrdata;
    if (l_wrvld) ln++;
  endtask

  task automatic do_reset(input logic e);
    @(negedge clk);
    rst = 1'b0; en = e; wrrdy = 1'b0; rdvld = 1'b0; l_rdvld = 1'b0;
    @(negedge clk);
    chk("rst_wrvld", wrvld, 1'b0);
    chk("rst_wrdata", wrdata, 16'h0000);
    chk("rst_wrtag", wrtag, 2'd0);
    chk("rst_rdrdy", rdrdy, 1'b0);
    chk("rst_errcntrs", errcntrs, 4'h0);
    chk("rst_errflgs", errflgs, 2'b00);
    chk("rst_tagerr", tagerr, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1; nacc = 0; c1 = 0;
    armed = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int c = 0; c < C; c++) begin
        ord_tag[i*C + c] = CW'(c);
        ord_dat[i*C + c] = W'(i * X);
      end
    rst = 1'b0; en = 1'b0; wrrdy = 1'b0; rdvld = 1'b0; rddata = '0; rdtag = '0;
    l_en = 1'b1; l_wrrdy = 1'b1; l_rdvld = 1'b0; l_rddata = '0; l_rdtag = '0;
    nacc = 0; c1 = 0; ln = 0;
    repeat (2) @(negedge clk);

    // plain loopback, sink always ready
    do_reset(1'b1);
    repeat (30) drive(1'b1, 0, 100);
    chk("lb_accepts", nacc, 20);
    chk("lb_w0", {f_tag[0], f_dat[0]}, {2'd0, 16'd0});
    chk("lb_w1", {f_tag[1], f_dat[1]}, {2'd1, 16'd0});
    chk("lb_w2", {f_tag[2], f_dat[2]}, {2'd0, 16'd1});
    chk("lb_w3", {f_tag[3], f_dat[3]}, {2'd1, 16'd1});
    chk("lb_done", done, 1'b1);
    chk("lb_wrvld_low", wrvld, 1'b0);
    chk("lb_errs", errcntrs, 4'h0);
    chk("lfsr_count", ln, 4);
    chk("lfsr_w0", lw[0], 16'h0001);
    chk("lfsr_w1", lw[1], 16'hB400);
    chk("lfsr_w2", lw[2], 16'h5A00);
    chk("lfsr_w3", lw[3], 16'h2D00);
    chk("lfsr_done", l_done, 1'b1);
    chk("lfsr_errs", {l_errcntrs, l_errflgs}, 9'd0);
    l_en = 1'b0;
    // a wrong beat after done is still checked
    @(negedge clk); rdvld = 1'b1; rdtag = 2'd0; rddata = 16'hFFFF;
    @(negedge clk); rdvld = 1'b0;
    @(negedge clk);
    chk("post_done_err", errcntrs, 4'b0001);
    chk("post_done_flg", errflgs, 2'b01);

    // random backpressure and enable drops
    do_reset(1'b1);
    repeat (80) drive($urandom_range(0, 9) != 0, 0, 50);
    repeat (60) drive(1'b1, 0, 50);
    chk("bp_done", done, 1'b1);
    chk("bp_flags", errflgs, 2'b00);

    // single corrupted word on channel 1
    do_reset(1'b1);
    repeat (30) drive(1'b1, 1, 100);
    chk("one_err_cnt", errcntrs, 4'b0100);
    chk("one_err_flg", errflgs, 2'b10);
    chk("one_err_done", done, 1'b1);

    // every channel-0 return inverted: counter saturates
    do_reset(1'b1);
    repeat (60) drive(1'b1, 2, 70);
    chk("sat_cnt", errcntrs, 4'b0011);
    chk("sat_flg", errflgs, 2'b01);

    // bad tag, then a reset in the middle of traffic
    do_reset(1'b0);
    repeat (3) drive(1'b0, 0, 100);
    @(negedge clk); rdvld = 1'b1; rdtag = 2'd3; rddata = 16'h0000;
    repeat (3) drive(1'b0, 0, 100);
    chk("badtag_flag", tagerr, 1'b1);
    chk("badtag_cnt", errcntrs, 4'h0);
    repeat (7) drive(1'b1, 0, 100);
    do_reset(1'b1);
    @(negedge clk);
    chk("restart_vld", wrvld, 1'b1);
    chk("restart_word", {wrtag, wrdata}, {2'd0, 16'd0});
    repeat (30) drive(1'b1, 0, 100);
    chk("restart_done", done, 1'b1);
    chk("restart_errs", {errcntrs, errflgs, tagerr}, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
